// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 16x oversampling, 3-sample majority vote, false-start and framing checks.
// Define UART_RX_PARITY_EN to add a parity bit (8E1/8O1) and the parity_err output.
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000
`ifdef UART_RX_PARITY_EN
   ,parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_set,
    input  logic       rs232_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
   ,output logic       parity_err
`endif
);

    localparam int unsigned Div0 = CLK_FREQ / (16 * 9600);
    localparam int unsigned Div1 = CLK_FREQ / (16 * 19200);
    localparam int unsigned Div2 = CLK_FREQ / (16 * 38400);
    localparam int unsigned Div3 = CLK_FREQ / (16 * 57600);
    localparam int unsigned Div4 = CLK_FREQ / (16 * 115200);
    localparam int unsigned CntW = (Div0 > 1) ? $clog2(Div0) : 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

    state_e          state_q, state_d;
    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    logic [2:0]      baud_q, baud_d;
    logic [CntW-1:0] div_cnt_q, div_cnt_d, div_max;
    logic [3:0]      tick_cnt_q, tick_cnt_d, tick_num;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [1:0]      smp_q, smp_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;
    logic            fall, tick, sample_now, decide, maj;
`ifdef UART_RX_PARITY_EN
    logic            par_bit_q, par_bit_d;
    logic            parity_err_q, parity_err_d;
    logic            par_exp;
`endif

    always_comb begin
        case (baud_q)
            3'd0:    div_max = CntW'(Div0 - 1);
            3'd1:    div_max = CntW'(Div1 - 1);
            3'd2:    div_max = CntW'(Div2 - 1);
            3'd3:    div_max = CntW'(Div3 - 1);
            default: div_max = CntW'(Div4 - 1);
        endcase
    end

    // Ticks are numbered from 1 within a bit; samples at ticks 7/8/9, decision at tick 9.
    assign fall       = rx_s3_q & ~rx_s2_q;
    assign tick       = (div_cnt_q == div_max);
    assign tick_num   = tick_cnt_q + 4'd1;
    assign sample_now = tick && (tick_num == 4'd7 || tick_num == 4'd8);
    assign decide     = tick && (tick_num == 4'd9);
    assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s2_q) | (smp_q[1] & rx_s2_q);
`ifdef UART_RX_PARITY_EN
    assign par_exp    = (^shift_q) ^ PARITY_ODD;
`endif

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        div_cnt_d   = div_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        smp_d       = smp_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        if (state_q != StIdle && state_q != StBreak) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                tick_cnt_d = tick_num;
            end
            if (sample_now) begin
                smp_d = {smp_q[0], rx_s2_q};
            end
        end
        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d    = StStart;
                    baud_d     = baud_set;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                end
            end
            StStart: begin
                if (decide) begin
                    state_d = maj ? StIdle : StData;
                end
            end
            StData: begin
                if (decide) begin
                    shift_d   = {maj, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (decide) begin
                    par_bit_d = maj;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (decide) begin
                    if (!maj) begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bit_q != par_exp) begin
                        parity_err_d = 1'b1;
                        state_d      = StIdle;
`endif
                    end else begin
                        rx_done_d = 1'b1;
                        data_d    = shift_q;
                        state_d   = StIdle;
                    end
                end
            end
            StBreak: begin
                if (rx_s2_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            baud_q      <= '0;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            smp_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_s1_q     <= rs232_rx;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            baud_q      <= baud_d;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            smp_q       <= smp_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_byte = data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at CLK_FREQ = 10 MHz (divisors 65, 32, 16, 10, 5).
module tb_uart_byte_rx;

    localparam int unsigned ClkFreq = 10_000_000;
    localparam int Bt0 = 16 * 65;   // 9600 bit time in clocks at this divisor
    localparam int Bt4 = 16 * 5;    // 115200 bit time
`ifdef UART_RX_PARITY_EN
    localparam int ExpLat = 10920;  // 10.5 bit times at baud 0
`else
    localparam int ExpLat = 9880;   // 9.5 bit times at baud 0
`endif
    localparam int LatTol = 2 * 65;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] baud_set = 3'd4;
    logic       rs232_rx = 1'b1;
    logic [7:0] data_byte;
    logic       rx_done, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, overlap = 0;
    int unsigned done_time = 0;
    logic [7:0] last_byte = 8'h00, prev_byte = 8'h00;

    uart_byte_rx #(
        .CLK_FREQ (ClkFreq)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_set  (baud_set),
        .rs232_rx  (rs232_rx),
        .data_byte (data_byte),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
       ,.parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt  = done_cnt + 1;
            done_time = cyc;
            prev_byte = last_byte;
            last_byte = data_byte;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (rx_done && frame_err) overlap = overlap + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perr_cnt = perr_cnt + 1;
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame: start, 8 data LSB first, [parity = even ^ flip], stop.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip,
                              input int bt);
        rs232_rx = 1'b0;
        wait_clks(bt);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            wait_clks(bt);
        end
`ifdef UART_RX_PARITY_EN
        rs232_rx = (^b) ^ par_flip;
        wait_clks(bt);
`endif
        rs232_rx = stop;
        wait_clks(bt);
    endtask

    initial begin
        int t0;
        int base;
        logic lat_ok;

        // Reset state
        wait_clks(5);
        check_eq("rst_data", 32'(data_byte), 32'h00);
        check_eq("rst_done", 32'(rx_done), 32'h0);
        check_eq("rst_ferr", 32'(frame_err), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        wait_clks(5);

        // Back-to-back at 115200
        send_frame(8'h55, 1'b1, 1'b0, Bt4);
        send_frame(8'hA5, 1'b1, 1'b0, Bt4);
        wait_clks(2 * Bt4);
        check_eq("b2b_count", 32'(done_cnt), 32'd2);
        check_eq("b2b_first", 32'(prev_byte), 32'h55);
        check_eq("b2b_second", 32'(last_byte), 32'hA5);
        check_eq("b2b_ferr", 32'(ferr_cnt), 32'd0);
        check_eq("b2b_busy", 32'(busy), 32'h0);

        // 9600 with latency measurement
        baud_set = 3'd0;
        wait_clks(5);
        t0 = int'(cyc);
        send_frame(8'h00, 1'b1, 1'b0, Bt0);
        wait_clks(Bt0);
        check_eq("b0_byte00", 32'(last_byte), 32'h00);
        lat_ok = ((int'(done_time) - t0) >= ExpLat - LatTol) &&
                 ((int'(done_time) - t0) <= ExpLat + LatTol);
        check_eq("b0_lat00", 32'(lat_ok), 32'h1);
        t0 = int'(cyc);
        send_frame(8'hFF, 1'b1, 1'b0, Bt0);
        wait_clks(Bt0);
        check_eq("b0_byteFF", 32'(last_byte), 32'hFF);
        lat_ok = ((int'(done_time) - t0) >= ExpLat - LatTol) &&
                 ((int'(done_time) - t0) <= ExpLat + LatTol);
        check_eq("b0_latFF", 32'(lat_ok), 32'h1);
        check_eq("b0_count", 32'(done_cnt), 32'd4);

        // False start: 4-tick glitch at 115200
        baud_set = 3'd4;
        wait_clks(5);
        rs232_rx = 1'b0;
        wait_clks(6);
        check_eq("glitch_busy_hi", 32'(busy), 32'h1);
        wait_clks(14);
        rs232_rx = 1'b1;
        wait_clks(3 * Bt4);
        check_eq("glitch_busy_lo", 32'(busy), 32'h0);
        check_eq("glitch_done", 32'(done_cnt), 32'd4);
        check_eq("glitch_ferr", 32'(ferr_cnt), 32'd0);

        // Bad stop bit then break held for 3 bytes
        send_frame(8'h3C, 1'b0, 1'b0, Bt4);
        wait_clks(10 * Bt4);
        check_eq("brk_busy", 32'(busy), 32'h1);
        wait_clks(20 * Bt4);
        rs232_rx = 1'b1;
        wait_clks(2 * Bt4);
        check_eq("brk_ferr", 32'(ferr_cnt), 32'd1);
        check_eq("brk_done", 32'(done_cnt), 32'd4);
        check_eq("brk_hold", 32'(data_byte), 32'hFF);
        send_frame(8'h81, 1'b1, 1'b0, Bt4);
        wait_clks(Bt4);
        check_eq("brk_next", 32'(last_byte), 32'h81);
        check_eq("brk_next_cnt", 32'(done_cnt), 32'd5);

        // Reset in the middle of data bit 4
        fork
            send_frame(8'h5A, 1'b1, 1'b0, Bt4);
            begin
                wait_clks(5 * Bt4 + Bt4 / 2);
                rst = 1'b0;
            end
        join
        wait_clks(5);
        rst = 1'b1;
        wait_clks(Bt4);
        check_eq("rstmid_done", 32'(done_cnt), 32'd5);
        check_eq("rstmid_ferr", 32'(ferr_cnt), 32'd1);
        check_eq("rstmid_data", 32'(data_byte), 32'h00);
        check_eq("rstmid_busy", 32'(busy), 32'h0);
        send_frame(8'h7E, 1'b1, 1'b0, Bt4);
        wait_clks(Bt4);
        check_eq("after_rst", 32'(last_byte), 32'h7E);
        check_eq("after_rst_cnt", 32'(done_cnt), 32'd6);

`ifdef UART_RX_PARITY_EN
        // Even parity: good then bad
        send_frame(8'h03, 1'b1, 1'b0, Bt4);
        wait_clks(Bt4);
        check_eq("par_ok_byte", 32'(last_byte), 32'h03);
        check_eq("par_ok_cnt", 32'(done_cnt), 32'd7);
        send_frame(8'h03, 1'b1, 1'b1, Bt4);
        wait_clks(Bt4);
        check_eq("par_bad_err", 32'(perr_cnt), 32'd1);
        check_eq("par_bad_cnt", 32'(done_cnt), 32'd7);
`endif

        check_eq("no_overlap", 32'(overlap), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
